// File: rtl/sram_burst_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two burst masters.
// Sequences 1..16-beat bursts at consecutive (wrapping) word addresses.
module sram_burst_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_write,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m0_len,
  input  logic [3:0]        m1_len,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_wready,
  output logic              m1_wready,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              m0_last,
  output logic              m1_last,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, RD_TAIL, WR} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        beat_q, beat_d;
  logic              rr_q, rr_d;
  logic              rvld_q, rvld_d;
  logic              rlast_q, rlast_d;

  logic gnt, sel1, wready, wlast, rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      rr_q    <= 1'b0;
      rvld_q  <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      rr_q    <= rr_d;
      rvld_q  <= rvld_d;
      rlast_q <= rlast_d;
    end
  end

  // rr_q = 1 means m1 wins a tie
  assign sel1 = m1_req & (~m0_req | rr_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    rr_d       = rr_q;
    rvld_d     = 1'b0;
    rlast_d    = 1'b0;
    gnt        = 1'b0;
    wready     = 1'b0;
    wlast      = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if ((m0_req | m1_req) & ~rst) begin
          gnt     = 1'b1;
          owner_d = sel1;
          base_d  = sel1 ? m1_addr : m0_addr;
          len_d   = sel1 ? m1_len : m0_len;
          beat_d  = '0;
          rr_d    = ~sel1;
          state_d = (sel1 ? m1_write : m0_write) ? WR : RD;
        end
      end
      RD: begin
        sram_cs   = 1'b1;
        sram_addr = base_q + ADDR_W'(beat_q);
        rvld_d    = 1'b1;
        rlast_d   = (beat_q == len_q);
        if (beat_q == len_q) state_d = RD_TAIL;
        else beat_d = beat_q + 4'd1;
      end
      RD_TAIL: state_d = IDLE;
      WR: begin
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = base_q + ADDR_W'(beat_q);
        sram_wdata = owner_q ? m1_wdata : m0_wdata;
        wready     = 1'b1;
        wlast      = (beat_q == len_q);
        if (beat_q == len_q) state_d = IDLE;
        else beat_d = beat_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rlast     = rvld_q & rlast_q;
  assign m0_gnt    = gnt & ~sel1;
  assign m1_gnt    = gnt & sel1;
  assign m0_wready = wready & ~owner_q;
  assign m1_wready = wready & owner_q;
  assign m0_rvalid = rvld_q & ~owner_q;
  assign m1_rvalid = rvld_q & owner_q;
  assign m0_last   = (wlast | rlast) & ~owner_q;
  assign m1_last   = (wlast | rlast) & owner_q;
  assign m0_rdata  = m0_rvalid ? sram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? sram_rdata : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Directed bench for sram_burst_arbiter with a behavioural SRAM model.
// Vector table of single bursts plus hand-written reset/contention sequences.
module tb_sram_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_write, m1_write;
  logic [13:0] m0_addr, m1_addr;
  logic [3:0]  m0_len, m1_len;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_wready, m1_wready;
  logic        m0_rvalid, m1_rvalid, m0_last, m1_last;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_cs, sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  sram_burst_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_write(m0_write), .m1_write(m1_write),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_len(m0_len), .m1_len(m1_len),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_wready(m0_wready), .m1_wready(m1_wready),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_last(m0_last), .m1_last(m1_last),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .busy(busy)
  );

  logic [31:0] mem [0:16383];
  bit          wflag [0:16383];

  always @(posedge clk) begin
    if (sram_cs && sram_we) begin
      mem[sram_addr]   <= sram_wdata;
      wflag[sram_addr] <= 1'b1;
    end
    if (sram_cs && !sram_we) sram_rdata <= mem_rd(sram_addr);
  end

  function automatic logic [31:0] mem_rd(input logic [13:0] a);
    return wflag[a] ? mem[a] : {16'h5EED, 2'b00, a};
  endfunction

  function automatic logic [31:0] wpat(input bit m, input logic [13:0] a);
    return {(m ? 16'hB1B1 : 16'hA0A0), 2'b00, a};
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      cyc();
      #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  typedef struct {
    bit          m;
    bit          wr;
    logic [13:0] addr;
    logic [3:0]  len;
    logic [13:0] exp_last;
    int          exp_cyc;
  } vec_t;

  task automatic burst(input vec_t v);
    int  acc = 0, rv = 0, busyc = 0;
    int  first_acc = -1, first_rv = -1;
    bit  other_bad = 1'b0;
    logic [13:0] lastaddr = '0;
    logic [13:0] cur;
    logic [13:0] q[$];
    logic o_wr, o_rv, o_last, o_gnt;
    logic [31:0] o_rdata;
    cyc();
    if (v.m) begin
      m1_req = 1; m1_write = v.wr; m1_addr = v.addr; m1_len = v.len;
    end else begin
      m0_req = 1; m0_write = v.wr; m0_addr = v.addr; m0_len = v.len;
    end
    #1;
    chk("gnt", v.m ? m1_gnt : m0_gnt, 1);
    chk("gnt_other", v.m ? m0_gnt : m1_gnt, 0);
    chk("busy_at_gnt", busy, 0);
    for (int c = 1; c <= 40; c++) begin
      cyc();
      m0_req = 0;
      m1_req = 0;
      cur = v.addr + 14'(acc);
      if (v.m) m1_wdata = wpat(1'b1, cur);
      else m0_wdata = wpat(1'b0, cur);
      #1;
      if (!busy) break;
      busyc++;
      o_wr    = v.m ? m1_wready : m0_wready;
      o_rv    = v.m ? m1_rvalid : m0_rvalid;
      o_last  = v.m ? m1_last : m0_last;
      o_gnt   = v.m ? m1_gnt : m0_gnt;
      o_rdata = v.m ? m1_rdata : m0_rdata;
      if (v.m) other_bad |= m0_gnt | m0_wready | m0_rvalid | m0_last | (m0_rdata != 0);
      else other_bad |= m1_gnt | m1_wready | m1_rvalid | m1_last | (m1_rdata != 0);
      other_bad |= o_gnt;
      if (!v.wr) other_bad |= o_wr;
      if (!o_wr && !o_rv) other_bad |= o_last;
      if (sram_cs) begin
        if (first_acc < 0) first_acc = c;
        chk("addr", sram_addr, cur);
        chk("we", sram_we, v.wr);
        if (v.wr) begin
          chk("wdata", sram_wdata, wpat(v.m, cur));
          chk("wready", o_wr, 1);
          chk("wlast", o_last, acc == v.len);
        end
        lastaddr = sram_addr;
        q.push_back(sram_addr);
        acc++;
      end
      if (o_rv) begin
        if (first_rv < 0) first_rv = c;
        if (q.size() == 0) chk("rvalid_early", o_rv, 0);
        else chk("rdata", o_rdata, mem_rd(q.pop_front()));
        chk("rlast", o_last, rv == v.len);
        rv++;
      end
    end
    chk("accesses", acc, v.len + 1);
    chk("rvalids", rv, v.wr ? 0 : v.len + 1);
    chk("busy_cycles", busyc, v.exp_cyc);
    chk("last_addr", lastaddr, v.exp_last);
    chk("first_access_cycle", first_acc, 1);
    if (!v.wr) chk("first_rvalid_cycle", first_rv, 2);
    chk("other_quiet", other_bad, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int pend0, pend1, k, idle_run;
    bit overlap, late_rv;
    bit order[4];

    vecs[0] = '{1'b0, 1'b0, 14'h0010, 4'd3,  14'h0013, 5};
    vecs[1] = '{1'b1, 1'b1, 14'h3FFF, 4'd2,  14'h0001, 3};
    vecs[2] = '{1'b0, 1'b1, 14'h0020, 4'd0,  14'h0020, 1};
    vecs[3] = '{1'b1, 1'b0, 14'h3FFE, 4'd3,  14'h0001, 5};
    vecs[4] = '{1'b0, 1'b0, 14'h0020, 4'd0,  14'h0020, 2};
    vecs[5] = '{1'b1, 1'b1, 14'h0100, 4'd15, 14'h010F, 16};
    vecs[6] = '{1'b0, 1'b0, 14'h0100, 4'd15, 14'h010F, 17};

    rst = 1;
    m0_req = 0; m1_req = 0; m0_write = 0; m1_write = 0;
    m0_addr = '0; m1_addr = '0; m0_len = '0; m1_len = '0;
    m0_wdata = '0; m1_wdata = '0;
    repeat (3) cyc();
    rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cs", sram_cs, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_outs", {m0_gnt, m1_gnt, m0_wready, m1_wready,
                     m0_rvalid, m1_rvalid, m0_last, m1_last}, 0);

    for (int i = 0; i < 7; i++) burst(vecs[i]);

    // reset during write beat 1; previous grant left rr favouring m1
    cyc();
    m0_req = 1; m0_write = 1; m0_addr = 14'h0200; m0_len = 4'd5;
    m0_wdata = wpat(1'b0, 14'h0200);
    #1;
    chk("t1_gnt", m0_gnt, 1);
    cyc();
    m0_req = 0;
    #1;
    chk("t1_beat0", m0_wready, 1);
    cyc();
    m0_wdata = wpat(1'b0, 14'h0201);
    rst = 1;
    #1;
    chk("t1_beat1_addr", sram_addr, 14'h0201);
    cyc();
    #1;
    chk("t1_rst_cs", sram_cs, 0);
    chk("t1_rst_wready", m0_wready, 0);
    chk("t1_rst_busy", busy, 0);
    cyc();
    #1;
    chk("t1_rst2_outs", {sram_cs, m0_wready, busy, m0_gnt, m1_gnt}, 0);
    cyc();
    rst = 0;
    m0_req = 1; m1_req = 1; m0_write = 0; m1_write = 0;
    m0_len = 0; m1_len = 0;
    #1;
    chk("t1_rr_m0", {m0_gnt, m1_gnt}, 2'b10);
    cyc();
    m0_req = 0; m1_req = 0;
    #1;
    wait_idle();

    // reset mid-read abandons the burst and its in-flight rvalid
    cyc();
    m1_req = 1; m1_write = 0; m1_addr = 14'h0300; m1_len = 4'd7;
    #1;
    chk("t6_gnt", m1_gnt, 1);
    cyc();
    m1_req = 0;
    cyc();
    cyc();
    #1;
    chk("t6_beat2_addr", sram_addr, 14'h0302);
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("t6_rst_outs", {sram_cs, m1_rvalid, busy, m1_last}, 0);
    late_rv = 0;
    repeat (4) begin
      cyc();
      #1;
      late_rv |= m1_rvalid | sram_cs;
    end
    chk("t6_no_late_rvalid", late_rv, 0);
    burst('{1'b1, 1'b0, 14'h0300, 4'd7, 14'h0307, 9});

    // contention: both masters, two bursts each, from reset
    cyc();
    rst = 1;
    repeat (2) cyc();
    rst = 0;
    pend0 = 2; pend1 = 2; k = 0; idle_run = 0; overlap = 0;
    m0_addr = 14'h0400; m1_addr = 14'h0500;
    m0_len = 1; m1_len = 1; m0_write = 0; m1_write = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      m0_req = (pend0 > 0);
      m1_req = (pend1 > 0);
      #1;
      if (m0_gnt && m1_gnt) overlap = 1;
      if ((m0_gnt || m1_gnt) && busy) overlap = 1;
      if (!busy) idle_run++;
      if (m0_gnt || m1_gnt) begin
        order[k] = m1_gnt;
        if (k > 0) chk("t3_idle_gap", idle_run, 1);
        k++;
        idle_run = 0;
        if (m1_gnt) pend1--;
        else pend0--;
      end
      cyc();
    end
    m0_req = 0; m1_req = 0;
    chk("t3_grants", k, 4);
    for (int i = 0; i < 4; i++) chk("t3_order", order[i], i % 2);
    chk("t3_no_overlap", overlap, 0);
    #1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
